// File: rtl/aes_mask_gen.sv
// Multi-round AES mask generator: WIDTH-bit mask state plus rotating round key, driven by
// an IDLE/ROUND FSM with ready/valid. Optional zeroize input under AES_MASK_GEN_ZEROIZE_EN.
module aes_mask_gen #(
  parameter int WIDTH  = 128,
  parameter int ROUNDS = 10,
  parameter int ROT0   = 19,
  parameter int ROT1   = 22
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             init,
  input  logic             next,
  input  logic             finalize,
`ifdef AES_MASK_GEN_ZEROIZE_EN
  input  logic             zeroize,
`endif
  input  logic [WIDTH-1:0] key,
  input  logic             keylen,
  input  logic [WIDTH-1:0] block,
  output logic [WIDTH-1:0] result,
  output logic             ready,
  output logic             valid
);

  localparam int CW = $clog2(ROUNDS) + 1;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUND = 1'b1
  } fsm_t;

  fsm_t             fsm_r, fsm_s;
  logic [WIDTH-1:0] state_r, state_s;
  logic [WIDTH-1:0] round_key_r, round_key_s;
  logic             key_sel_r, key_sel_s;
  logic [CW-1:0]    round_ctr_r, round_ctr_s;
  logic             valid_r, valid_s;

  function automatic logic [WIDTH-1:0] rot_key(input logic [WIDTH-1:0] v, input logic sel);
    if (sel) begin
      rot_key = (v >> ROT1) | (v << (WIDTH - ROT1));
    end else begin
      rot_key = (v >> ROT0) | (v << (WIDTH - ROT0));
    end
  endfunction

  // Next-state and datapath update; commands only sampled in IDLE, init > next > finalize
  always_comb begin
    fsm_s       = fsm_r;
    state_s     = state_r;
    round_key_s = round_key_r;
    key_sel_s   = key_sel_r;
    round_ctr_s = round_ctr_r;
    valid_s     = valid_r;
    case (fsm_r)
      IDLE: begin
        if (init) begin
          state_s     = block;
          round_key_s = key;
          key_sel_s   = keylen;
          valid_s     = 1'b0;
        end else if (next) begin
          fsm_s       = ROUND;
          round_ctr_s = '0;
          valid_s     = 1'b0;
        end else if (finalize) begin
          state_s     = state_r ^ block;
          round_key_s = round_key_r ^ key;
          valid_s     = 1'b1;
        end else begin
          fsm_s = IDLE;
        end
      end
      ROUND: begin
        state_s     = state_r ^ round_key_r;
        round_key_s = rot_key(round_key_r, key_sel_r);
        if (round_ctr_r == LAST_ROUND) begin
          fsm_s       = IDLE;
          round_ctr_s = '0;
        end else begin
          round_ctr_s = round_ctr_r + CW'(1);
        end
      end
      default: begin
        fsm_s       = IDLE;
        round_ctr_s = '0;
      end
    endcase
`ifdef AES_MASK_GEN_ZEROIZE_EN
    // Zeroize overrides everything, including a run in progress
    if (zeroize) begin
      fsm_s       = IDLE;
      state_s     = '0;
      round_key_s = '0;
      key_sel_s   = 1'b0;
      round_ctr_s = '0;
      valid_s     = 1'b0;
    end else begin
      fsm_s = fsm_s;
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_r       <= IDLE;
      state_r     <= '0;
      round_key_r <= '0;
      key_sel_r   <= 1'b0;
      round_ctr_r <= '0;
      valid_r     <= 1'b0;
    end else begin
      fsm_r       <= fsm_s;
      state_r     <= state_s;
      round_key_r <= round_key_s;
      key_sel_r   <= key_sel_s;
      round_ctr_r <= round_ctr_s;
      valid_r     <= valid_s;
    end
  end

  assign result = state_r;
  assign ready  = (fsm_r == IDLE);
  assign valid  = valid_r;

endmodule

// File: tb/tb_aes_mask_gen.sv
// Self-checking bench for aes_mask_gen (ROUNDS=2): behavioural model compared every cycle,
// plus hand-computed literals. Zeroize checks only when AES_MASK_GEN_ZEROIZE_EN is defined.
module tb_aes_mask_gen;
  localparam int W  = 128;
  localparam int NR = 2;
  localparam int R0 = 19;
  localparam int R1 = 22;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init = 1'b0, next = 1'b0, finalize = 1'b0, keylen = 1'b0;
  logic [W-1:0] key = '0, block = '0;
  logic [W-1:0] result;
  logic ready, valid;
`ifdef AES_MASK_GEN_ZEROIZE_EN
  logic zeroize = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  aes_mask_gen #(.WIDTH(W), .ROUNDS(NR), .ROT0(R0), .ROT1(R1)) dut (
    .clk(clk), .reset_n(reset_n), .init(init), .next(next), .finalize(finalize),
`ifdef AES_MASK_GEN_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .key(key), .keylen(keylen), .block(block),
    .result(result), .ready(ready), .valid(valid)
  );

  always #5 clk = ~clk;

  // Reference model: rounds remaining instead of a state machine
  logic [W-1:0] m_state, m_rk;
  logic m_sel, m_valid;
  int m_left;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int amt);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[(i + amt) % W];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= '0; m_rk <= '0; m_sel <= 1'b0; m_valid <= 1'b0; m_left <= 0;
    end
`ifdef AES_MASK_GEN_ZEROIZE_EN
    else if (zeroize) begin
      m_state <= '0; m_rk <= '0; m_sel <= 1'b0; m_valid <= 1'b0; m_left <= 0;
    end
`endif
    else if (m_left != 0) begin
      m_state <= m_state ^ m_rk;
      m_rk    <= rotr(m_rk, m_sel ? R1 : R0);
      m_left  <= m_left - 1;
    end else if (init) begin
      m_state <= block; m_rk <= key; m_sel <= keylen; m_valid <= 1'b0;
    end else if (next) begin
      m_left <= NR; m_valid <= 1'b0;
    end else if (finalize) begin
      m_state <= m_state ^ block; m_rk <= m_rk ^ key; m_valid <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc_result", result, m_state);
      chk("cyc_ready", W'(ready), W'(m_left == 0));
      chk("cyc_valid", W'(valid), W'(m_valid));
      chk("cyc_round_key", dut.round_key_r, m_rk);
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_cmds();
    init = 1'b0; next = 1'b0; finalize = 1'b0;
  endtask

  logic [W-1:0] tmp, exp_rk;
  int low_cnt;

  initial begin
    cyc(2);
    #3 reset_n = 1'b1;
    cyc(1);
    chk("reset_result", result, '0);
    chk("reset_ready", W'(ready), W'(1));
    chk("reset_valid", W'(valid), W'(0));

    // Two rounds, keylen=0, key=1
    block = '0; key = W'(1); keylen = 1'b0; init = 1'b1;
    cyc(1);
    init = 1'b0; next = 1'b1;
    cyc(1);
    next = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 6 && !ready; i++) begin
      low_cnt++;
      cyc(1);
    end
    chk("run_ready_low_cycles", W'(low_cnt), W'(NR));
    chk("run_result", result, 128'h00002000_00000000_00000000_00000001);
    chk("run_round_key", dut.round_key_r, 128'h00000000_04000000_00000000_00000000);

    // Finalize then next clears valid
    block = {W{1'b1}}; key = '0; finalize = 1'b1;
    cyc(1);
    finalize = 1'b0;
    chk("final_result", result, 128'hFFFFDFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE);
    chk("final_valid", W'(valid), W'(1));
    next = 1'b1;
    cyc(1);
    next = 1'b0;
    chk("next_clears_valid", W'(valid), W'(0));
    cyc(NR);

    // All commands at once: init wins
    tmp = {$urandom, $urandom, $urandom, $urandom};
    block = tmp; key = {$urandom, $urandom, $urandom, $urandom};
    init = 1'b1; next = 1'b1; finalize = 1'b1;
    cyc(1);
    clr_cmds();
    chk("prio_ready", W'(ready), W'(1));
    chk("prio_result", result, tmp);
    chk("prio_valid", W'(valid), W'(0));

    // next during ROUND ignored
    next = 1'b1;
    cyc(1);
    cyc(1);
    next = 1'b0;
    low_cnt = 1;
    for (int i = 0; i < 6 && !ready; i++) begin
      low_cnt++;
      cyc(1);
    end
    chk("ignored_next_run_len", W'(low_cnt), W'(NR));

    // keylen latched at init; toggled during run
    block = '0; key = W'(1); keylen = 1'b1; init = 1'b1;
    cyc(1);
    init = 1'b0; next = 1'b1;
    cyc(1);
    next = 1'b0; keylen = 1'b0;
    cyc(NR);
    exp_rk = W'(1) << 84;
    chk("keylen_round_key", dut.round_key_r, exp_rk);
    tmp = (W'(1) << 106) | W'(1);
    chk("keylen_result", result, tmp);

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_result", result, '0);
    chk("async_rst_ready", W'(ready), W'(1));
    chk("async_rst_valid", W'(valid), W'(0));
    #2 reset_n = 1'b1;
    cyc(1);

`ifdef AES_MASK_GEN_ZEROIZE_EN
    block = W'(5); key = W'(3); init = 1'b1;
    cyc(1);
    init = 1'b0; next = 1'b1;
    cyc(1);
    next = 1'b0;
    cyc(1);
    zeroize = 1'b1;
    cyc(1);
    zeroize = 1'b0;
    chk("zeroize_result", result, '0);
    chk("zeroize_ready", W'(ready), W'(1));
    chk("zeroize_valid", W'(valid), W'(0));
    block = W'(9); init = 1'b1;
    cyc(1);
    init = 1'b0;
    chk("zeroize_reinit", result, W'(9));
`endif

    // Randomised command traffic
    for (int i = 0; i < 400; i++) begin
      init     = ($urandom_range(0, 9) == 0);
      next     = ($urandom_range(0, 4) == 0);
      finalize = ($urandom_range(0, 5) == 0);
      keylen   = $urandom_range(0, 1);
      key      = {$urandom, $urandom, $urandom, $urandom};
      block    = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_MASK_GEN_ZEROIZE_EN
      zeroize  = ($urandom_range(0, 49) == 0);
`endif
      cyc(1);
    end
    clr_cmds();
`ifdef AES_MASK_GEN_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
